mem_arbiter: RTL and testbench

//   Shares the single-port 32x8 unified memory between two requesters:
//   - CPU port: control-unit fetch, LOAD and STORE.
//   - DBG port: program loader / debug monitor.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_if.sv | 15 +
 rtl/mem_arbiter_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_WAIT   = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DBG = 1'b1;

  // Wait counter width covers memory latencies up to 7 cycles.
  localparam int WAIT_W = 3;

  // Value loaded in ACCESS: cycles still to wait after the strobe cycle.
  function automatic logic [WAIT_W-1:0] wait_load(input int lat);
    return WAIT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side req/ack port: one instance per requester (CPU, DBG).
interface mem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational winner select for the arbiter.
// MEM_ARB_ROUND_ROBIN_EN: when defined, simultaneous requests alternate
// between ports; otherwise the CPU always wins and last_gnt is ignored.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_id
);

  assign gnt_valid = cpu_req | dbg_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On a tie, serve whichever port did not get the last access.
  always_comb begin
    gnt_id = GNT_CPU;
    if (cpu_req && dbg_req) gnt_id = (last_gnt == GNT_CPU) ? GNT_DBG : GNT_CPU;
    else if (dbg_req)       gnt_id = GNT_DBG;
  end
`else
  // Fixed priority: CPU first, DBG only when CPU is idle.
  always_comb begin
    gnt_id = GNT_CPU;
    if (!cpu_req && dbg_req) gnt_id = GNT_DBG;
  end

  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the CPU and the debug loader.
// Each access: IDLE -> ACCESS (strobe) -> WAIT (latency) -> RESP (ack).
// Build option: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_if.slave      cpu,
  mem_arbiter_if.slave      dbg,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef struct packed {
    logic              gnt;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  localparam logic [WAIT_W-1:0] WAIT_INIT = wait_load(MEM_LAT);

  arb_state_t        state, state_nxt;
  cmd_t              cmd;
  logic [WAIT_W-1:0] wait_cnt;
  logic              last_gnt;
  logic              gnt_valid, gnt_id;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

  mem_arb_pick u_pick (
    .cpu_req   (cpu.req),
    .dbg_req   (dbg.req),
    .last_gnt  (last_gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // State register; reset abandons any transaction without an ack.
  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  // Next state and memory-side outputs; the memory bus is only driven in ACCESS.
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state != ARB_IDLE);
    unique case (state)
      ARB_IDLE:   if (gnt_valid) state_nxt = ARB_ACCESS;
      ARB_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = cmd.we;
        mem_addr  = cmd.addr;
        mem_wdata = cmd.wdata;
        state_nxt = (MEM_LAT > 1) ? ARB_WAIT : ARB_RESP;
      end
      // Leave on the cycle the counter steps from 1 to 0.
      ARB_WAIT:   if (wait_cnt <= WAIT_W'(1)) state_nxt = ARB_RESP;
      ARB_RESP:   state_nxt = ARB_IDLE;
      default:    state_nxt = ARB_IDLE;
    endcase
  end

  // Latency counter: loaded on the strobe, counts down through WAIT.
  always_ff @(posedge clk) begin
    if (reset)                                      wait_cnt <= '0;
    else if (state == ARB_ACCESS)                   wait_cnt <= WAIT_INIT;
    else if (state == ARB_WAIT && wait_cnt != '0)   wait_cnt <= wait_cnt - WAIT_W'(1);
  end

  // Command latch: winner's grant and request fields captured when leaving IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd <= '0;
    end else if (state == ARB_IDLE && gnt_valid) begin
      if (gnt_id == GNT_DBG) cmd <= '{gnt: GNT_DBG, we: dbg.we, addr: dbg.addr, wdata: dbg.wdata};
      else                   cmd <= '{gnt: GNT_CPU, we: cpu.we, addr: cpu.addr, wdata: cpu.wdata};
    end
  end

  // Remember who was served last; only the round-robin picker reads it.
  always_ff @(posedge clk) begin
    if (reset)                    last_gnt <= GNT_DBG;
    else if (state == ARB_ACCESS) last_gnt <= cmd.gnt;
  end

  // Read data captured on the edge into RESP; writes leave it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else if (state != ARB_RESP && state_nxt == ARB_RESP && !cmd.we) begin
      if (cmd.gnt == GNT_DBG) dbg_rdata_q <= mem_rdata;
      else                    cpu_rdata_q <= mem_rdata;
    end
  end

  assign cpu.ack   = (state == ARB_RESP) && (cmd.gnt == GNT_CPU);
  assign dbg.ack   = (state == ARB_RESP) && (cmd.gnt == GNT_DBG);
  assign cpu.rdata = cpu_rdata_q;
  assign dbg.rdata = dbg_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance 0 uses MEM_LAT=1, instance 1 MEM_LAT=3.
// Each instance has a memory model that only presents valid read data once the
// configured latency has elapsed (0xEE otherwise).
module tb_mem_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          cpu_req [2], cpu_we [2], dbg_req [2], dbg_we [2];
  logic [AW-1:0] cpu_addr [2], dbg_addr [2];
  logic [DW-1:0] cpu_wdata [2], dbg_wdata [2];
  logic          cpu_ack [2], dbg_ack [2], mem_en [2], mem_we [2], busy [2];
  logic [DW-1:0] cpu_rdata [2], dbg_rdata [2], mem_wdata [2];
  logic [AW-1:0] mem_addr [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_if ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dbg_if ();
    logic          en_w, we_w, busy_w;
    logic [AW-1:0] addr_w, lat_addr;
    logic [DW-1:0] wdata_w, rdata_w;
    logic [DW-1:0] mem [32];
    int            lat_cnt;

    assign cpu_if.req   = cpu_req[g];
    assign cpu_if.we    = cpu_we[g];
    assign cpu_if.addr  = cpu_addr[g];
    assign cpu_if.wdata = cpu_wdata[g];
    assign dbg_if.req   = dbg_req[g];
    assign dbg_if.we    = dbg_we[g];
    assign dbg_if.addr  = dbg_addr[g];
    assign dbg_if.wdata = dbg_wdata[g];
    assign cpu_ack[g]   = cpu_if.ack;
    assign cpu_rdata[g] = cpu_if.rdata;
    assign dbg_ack[g]   = dbg_if.ack;
    assign dbg_rdata[g] = dbg_if.rdata;
    assign mem_en[g]    = en_w;
    assign mem_we[g]    = we_w;
    assign mem_addr[g]  = addr_w;
    assign mem_wdata[g] = wdata_w;
    assign busy[g]      = busy_w;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu       (cpu_if.slave),
      .dbg       (dbg_if.slave),
      .mem_en    (en_w),
      .mem_we    (we_w),
      .mem_addr  (addr_w),
      .mem_wdata (wdata_w),
      .mem_rdata (rdata_w),
      .busy      (busy_w)
    );

    // Memory model: preloaded while reset is high (addr 4 = A5, else addr+0x40).
    always @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < 32; i++) mem[i] <= (i == 4) ? 8'hA5 : 8'(i + 8'h40);
        lat_cnt  <= 0;
        lat_addr <= '0;
      end else if (en_w) begin
        if (we_w) mem[addr_w] <= wdata_w;
        lat_addr <= addr_w;
        lat_cnt  <= 1;
      end else if (lat_cnt < 8) begin
        lat_cnt <= lat_cnt + 1;
      end
    end

    always_comb begin
      rdata_w = 8'hEE;
      if (en_w) begin
        if (LAT == 1) rdata_w = mem[addr_w];
      end else if (lat_cnt == LAT - 1) begin
        rdata_w = mem[lat_addr];
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One transaction on one port; called and returns at a falling edge.
  task automatic do_txn(input int inst, input bit is_dbg, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                        input int exp_lat, input string name);
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    if (is_dbg) begin
      dbg_we[inst] = we; dbg_addr[inst] = addr; dbg_wdata[inst] = wdata; dbg_req[inst] = 1'b1;
    end else begin
      cpu_we[inst] = we; cpu_addr[inst] = addr; cpu_wdata[inst] = wdata; cpu_req[inst] = 1'b1;
    end
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = is_dbg ? dbg_ack[inst] : cpu_ack[inst];
      if (n == 1) begin
        check({name, ".mem_en"}, mem_en[inst], 1);
        check({name, ".mem_we"}, mem_we[inst], we);
        check({name, ".mem_addr"}, mem_addr[inst], addr);
      end else if (!got) begin
        check({name, ".wait_en"}, mem_en[inst], 0);
      end
    end
    check({name, ".ack_lat"}, n, exp_lat);
    check({name, ".rdata"}, is_dbg ? dbg_rdata[inst] : cpu_rdata[inst], exp_rdata);
    check({name, ".other_ack"}, is_dbg ? cpu_ack[inst] : dbg_ack[inst], 0);
    check({name, ".busy_resp"}, busy[inst], 1);
    if (is_dbg) dbg_req[inst] = 1'b0;
    else        cpu_req[inst] = 1'b0;
    @(negedge clk);
    check({name, ".idle_busy"}, busy[inst], 0);
    check({name, ".ack_pulse"}, is_dbg ? dbg_ack[inst] : cpu_ack[inst], 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit            is_dbg;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t tbl [7];
  int   order [4];
  int   ack_at [4];
  int   exp_order [4];
  int   k, n;
  logic seen;

  initial begin
    // port, we, addr, wdata, expected *_rdata after ack (writes keep old value)
    tbl[0] = '{0, 0, 5'h04, 8'h00, 8'hA5};
    tbl[1] = '{1, 1, 5'h1F, 8'h3C, 8'h00};
    tbl[2] = '{0, 0, 5'h1F, 8'h00, 8'h3C};
    tbl[3] = '{1, 0, 5'h04, 8'h00, 8'hA5};
    tbl[4] = '{0, 1, 5'h00, 8'h77, 8'h3C};
    tbl[5] = '{1, 0, 5'h00, 8'h00, 8'h77};
    tbl[6] = '{0, 0, 5'h10, 8'h00, 8'h50};
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif

    for (int g = 0; g < 2; g++) begin
      cpu_req[g] = 0; cpu_we[g] = 0; cpu_addr[g] = '0; cpu_wdata[g] = '0;
      dbg_req[g] = 0; dbg_we[g] = 0; dbg_addr[g] = '0; dbg_wdata[g] = '0;
    end

    // Reset held two edges with a CPU read pending: everything stays quiet.
    reset = 1'b1;
    cpu_addr[0] = 5'h10;
    cpu_req[0]  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("rst%0d.mem_en", c), mem_en[0], 0);
      check($sformatf("rst%0d.busy", c), busy[0], 0);
      check($sformatf("rst%0d.cpu_ack", c), cpu_ack[0], 0);
      check($sformatf("rst%0d.dbg_ack", c), dbg_ack[0], 0);
      check($sformatf("rst%0d.cpu_rdata", c), cpu_rdata[0], 0);
      check($sformatf("rst%0d.dbg_rdata", c), dbg_rdata[0], 0);
      check($sformatf("rst%0d.mem_addr", c), mem_addr[0], 0);
    end
    reset = 1'b0;
    do_txn(0, 0, 0, 5'h10, 8'h00, 8'h50, 2, "rst_first");

    // Single-port transactions at MEM_LAT=1.
    for (int i = 0; i < 7; i++)
      do_txn(0, tbl[i].is_dbg, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, 2,
             $sformatf("vec%0d", i));

    // Both ports requesting continuously: record grant order and ack spacing.
    do_reset();
    cpu_we[0] = 0; cpu_addr[0] = 5'h04; dbg_we[0] = 0; dbg_addr[0] = 5'h1F;
    cpu_req[0] = 1'b1; dbg_req[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin order[i] = -1; ack_at[i] = -1; end
    k = 0; n = 0;
    while (k < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (cpu_ack[0] || dbg_ack[0]) begin
        check($sformatf("arb%0d.one_ack", k), cpu_ack[0] & dbg_ack[0], 0);
        order[k]  = dbg_ack[0] ? 1 : 0;
        ack_at[k] = n;
        k++;
      end
    end
    cpu_req[0] = 1'b0; dbg_req[0] = 1'b0;
    check("arb.count", k, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("arb%0d.order", i), order[i], exp_order[i]);
      check($sformatf("arb%0d.ack_cycle", i), ack_at[i], 2 + 3 * i);
    end
    @(negedge clk);
    check("arb.idle_busy", busy[0], 0);

    // MEM_LAT=3: two WAIT cycles, ack four cycles after the request is sampled.
    do_txn(1, 0, 0, 5'h04, 8'h00, 8'hA5, 4, "lat3");

    // Reset during WAIT drops the read with no ack; next request is normal.
    cpu_we[1] = 0; cpu_addr[1] = 5'h1F; cpu_req[1] = 1'b1;
    @(negedge clk);
    check("rstw.access_en", mem_en[1], 1);
    @(negedge clk);
    check("rstw.wait_busy", busy[1], 1);
    check("rstw.wait_en", mem_en[1], 0);
    reset = 1'b1; cpu_req[1] = 1'b0;
    @(negedge clk);
    check("rstw.idle_busy", busy[1], 0);
    check("rstw.idle_en", mem_en[1], 0);
    check("rstw.idle_ack", cpu_ack[1], 0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | cpu_ack[1];
    end
    check("rstw.no_ack", seen, 0);
    do_txn(1, 0, 0, 5'h1F, 8'h00, 8'h5F, 4, "rstw_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
